// File: rtl/q_fxp_pkg.sv
// Shared fixed-point constants and helpers for the Q-learning update datapath.
// Helpers work on a wide signed accumulator so callers can clamp any width up to ACC_W.
package q_fxp_pkg;

   localparam int FRAC_BITS_DEF = 16;
   localparam int COEF_W_DEF    = FRAC_BITS_DEF + 1;
   localparam int ACC_W         = 128;

   localparam logic [COEF_W_DEF-1:0] FXP_0P5 = 17'h08000;
   localparam logic [COEF_W_DEF-1:0] FXP_0P9 = 17'h0E666;
   localparam logic [COEF_W_DEF-1:0] FXP_1P0 = 17'h10000;

   typedef logic signed [ACC_W-1:0] acc_t;

   // Clamp x into the signed range of a w-bit two's complement number.
   function automatic acc_t sat_to_width(input acc_t x, input int w);
      acc_t hi;
      acc_t lo;
      acc_t r;
      hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
      lo = -(acc_t'(1) <<< (w - 1));
      r  = x;
      if (x > hi) begin
         r = hi;
      end else if (x < lo) begin
         r = lo;
      end
      return r;
   endfunction

   function automatic acc_t rshift_round(input acc_t x, input int f, input bit rnd);
      acc_t b;
      b = x;
      if (rnd && (f > 0)) begin
         b = x + (acc_t'(1) <<< (f - 1));
      end
      return b >>> f;
   endfunction

endpackage

// File: rtl/fxp_mul_shift.sv
// Signed data times unsigned fixed-point coefficient, scaled back by >>>F with
// optional round-half-up, then clamped to OW bits with a clamp flag.
module fxp_mul_shift
   import q_fxp_pkg::*;
#(
   parameter int DW    = 32,
   parameter int CW    = 17,
   parameter int F     = 16,
   parameter int OW    = 33,
   parameter int ROUND = 0
) (
   input  logic signed [DW-1:0] data_i,
   input  logic        [CW-1:0] coef_i,
   output logic signed [OW-1:0] res_o,
   output logic                 sat_o
);

   localparam int PW = DW + CW + 1;

   logic signed [PW-1:0] data_ext;
   logic signed [PW-1:0] coef_ext;
   logic signed [PW-1:0] prod;
   acc_t                 prod_ext;
   acc_t                 shifted;
   acc_t                 clamped;

   assign data_ext = {{(CW + 1){data_i[DW-1]}}, data_i};
   assign coef_ext = {{(DW + 1){1'b0}}, coef_i};
   assign prod     = data_ext * coef_ext;
   assign prod_ext = acc_t'(prod);
   assign shifted  = rshift_round(prod_ext, F, ROUND != 0);
   assign clamped  = sat_to_width(shifted, OW);
   assign res_o    = clamped[OW-1:0];
   assign sat_o    = (clamped != shifted);

endmodule

// File: rtl/q_update_pipe.sv
// Four-stage fixed-point Q-update: q_new = q + alpha*(r + gamma*max_q - q).
// One beat per cycle; a single advance enable stalls every stage together.
module q_update_pipe
   import q_fxp_pkg::*;
#(
   parameter int                 DATA_WIDTH = 32,
   parameter int                 FRAC_BITS  = FRAC_BITS_DEF,
   parameter int                 TAG_WIDTH  = 8,
   parameter int                 ROUND      = 0,
   parameter logic [FRAC_BITS:0] ALPHA_INIT = FXP_0P5,
   parameter logic [FRAC_BITS:0] GAMMA_INIT = FXP_0P9,
   parameter int                 SATC_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [FRAC_BITS:0]    cfg_alpha,
   input  logic [FRAC_BITS:0]    cfg_gamma,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_q,
   input  logic [DATA_WIDTH-1:0] i_max_q,
   input  logic [DATA_WIDTH-1:0] i_rt,
   input  logic [TAG_WIDTH-1:0]  i_tag,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_q_new,
   output logic [TAG_WIDTH-1:0]  o_tag,
   output logic                  o_sat,
   output logic [SATC_WIDTH-1:0] o_sat_count
);

   localparam int W  = DATA_WIDTH;
   localparam int F  = FRAC_BITS;
   localparam int CW = FRAC_BITS + 1;

   logic                 adv;
   logic [CW-1:0]        alpha_q, gamma_q;

   logic                 s1_valid_q, s1_sat_q;
   logic signed [W:0]    s1_d_q, s1_pg_q;
   logic [W-1:0]         s1_q_q;
   logic [TAG_WIDTH-1:0] s1_tag_q;
   logic [CW-1:0]        s1_alpha_q;

   logic                 s2_valid_q, s2_sat_q;
   logic signed [W+1:0]  s2_td_q;
   logic [W-1:0]         s2_q_q;
   logic [TAG_WIDTH-1:0] s2_tag_q;
   logic [CW-1:0]        s2_alpha_q;

   logic                 s3_valid_q, s3_sat_q;
   logic signed [W+1:0]  s3_u_q;
   logic [W-1:0]         s3_q_q;
   logic [TAG_WIDTH-1:0] s3_tag_q;

   logic                 o_valid_q, o_sat_q;
   logic [W-1:0]         o_q_new_q;
   logic [TAG_WIDTH-1:0] o_tag_q;
   logic [SATC_WIDTH-1:0] sat_cnt_q;

   logic signed [W:0]    d_d, pg_d;
   logic                 pg_sat_d;
   logic signed [W+1:0]  td_d, u_d;
   logic                 u_sat_d;
   logic signed [W+2:0]  sum_d;
   acc_t                 sum_ext, sum_cl;
   logic [W-1:0]         q_new_d;
   logic                 sat_d;

   assign adv     = !o_valid_q || i_ready;
   assign o_ready = adv;

   assign d_d = {i_rt[W-1], i_rt} - {i_q[W-1], i_q};

   // The gamma product cannot exceed W+1 bits for coefficients below 2.0, but
   // its clamp flag is still folded into the beat's saturation status.
   fxp_mul_shift #(.DW(W), .CW(CW), .F(F), .OW(W + 1), .ROUND(ROUND)) u_gamma_mul (
      .data_i (i_max_q),
      .coef_i (gamma_q),
      .res_o  (pg_d),
      .sat_o  (pg_sat_d)
   );

   assign td_d = {s1_pg_q[W], s1_pg_q} + {s1_d_q[W], s1_d_q};

   fxp_mul_shift #(.DW(W + 2), .CW(CW), .F(F), .OW(W + 2), .ROUND(ROUND)) u_alpha_mul (
      .data_i (s2_td_q),
      .coef_i (s2_alpha_q),
      .res_o  (u_d),
      .sat_o  (u_sat_d)
   );

   assign sum_d   = {{3{s3_q_q[W-1]}}, s3_q_q} + {s3_u_q[W+1], s3_u_q};
   assign sum_ext = acc_t'(sum_d);
   assign sum_cl  = sat_to_width(sum_ext, W);
   assign q_new_d = sum_cl[W-1:0];
   assign sat_d   = s3_sat_q || (sum_cl != sum_ext);

   always_ff @(posedge clk) begin
      if (rst) begin
         alpha_q    <= ALPHA_INIT;
         gamma_q    <= GAMMA_INIT;
         s1_valid_q <= 1'b0;  s1_sat_q <= 1'b0;  s1_d_q <= '0;  s1_pg_q <= '0;
         s1_q_q     <= '0;    s1_tag_q <= '0;    s1_alpha_q <= '0;
         s2_valid_q <= 1'b0;  s2_sat_q <= 1'b0;  s2_td_q <= '0;
         s2_q_q     <= '0;    s2_tag_q <= '0;    s2_alpha_q <= '0;
         s3_valid_q <= 1'b0;  s3_sat_q <= 1'b0;  s3_u_q <= '0;
         s3_q_q     <= '0;    s3_tag_q <= '0;
         o_valid_q  <= 1'b0;  o_sat_q  <= 1'b0;  o_q_new_q <= '0;  o_tag_q <= '0;
         sat_cnt_q  <= '0;
      end else begin
         if (cfg_we) begin
            alpha_q <= cfg_alpha;
            gamma_q <= cfg_gamma;
         end
         if (adv) begin
            s1_valid_q <= i_valid;
            s1_sat_q   <= pg_sat_d;
            s1_d_q     <= d_d;
            s1_pg_q    <= pg_d;
            s1_q_q     <= i_q;
            s1_tag_q   <= i_tag;
            s1_alpha_q <= alpha_q;

            s2_valid_q <= s1_valid_q;
            s2_sat_q   <= s1_sat_q;
            s2_td_q    <= td_d;
            s2_q_q     <= s1_q_q;
            s2_tag_q   <= s1_tag_q;
            s2_alpha_q <= s1_alpha_q;

            s3_valid_q <= s2_valid_q;
            s3_sat_q   <= s2_sat_q || u_sat_d;
            s3_u_q     <= u_d;
            s3_q_q     <= s2_q_q;
            s3_tag_q   <= s2_tag_q;

            o_valid_q  <= s3_valid_q;
            o_sat_q    <= sat_d;
            o_q_new_q  <= q_new_d;
            o_tag_q    <= s3_tag_q;
         end
         if (o_valid_q && i_ready && o_sat_q && !(&sat_cnt_q)) begin
            sat_cnt_q <= sat_cnt_q + 1'b1;
         end
      end
   end

   assign o_valid     = o_valid_q;
   assign o_q_new     = o_q_new_q;
   assign o_tag       = o_tag_q;
   assign o_sat       = o_sat_q;
   assign o_sat_count = sat_cnt_q;

endmodule

// File: tb/tb_q_update_pipe.sv
// Randomised scoreboard bench for q_update_pipe against a plain-arithmetic reference.
`timescale 1ns/1ps
module tb_q_update_pipe;

   localparam int W = 32;
   localparam int F = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [16:0] cfg_alpha = '0, cfg_gamma = '0;
   logic        i_valid = 1'b0, o_ready;
   logic [31:0] i_q = '0, i_max_q = '0, i_rt = '0;
   logic [7:0]  i_tag = '0;
   logic        o_valid, i_ready = 1'b1;
   logic [31:0] o_q_new;
   logic [7:0]  o_tag;
   logic        o_sat;
   logic [15:0] o_sat_count;

   q_update_pipe #(.DATA_WIDTH(32), .FRAC_BITS(16), .TAG_WIDTH(8), .ROUND(0),
                   .ALPHA_INIT(17'h08000), .GAMMA_INIT(17'h0E666), .SATC_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_alpha(cfg_alpha), .cfg_gamma(cfg_gamma),
      .i_valid(i_valid), .o_ready(o_ready), .i_q(i_q), .i_max_q(i_max_q), .i_rt(i_rt),
      .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready), .o_q_new(o_q_new),
      .o_tag(o_tag), .o_sat(o_sat), .o_sat_count(o_sat_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] q;
      logic [7:0]  tag;
      logic        sat;
   } exp_t;

   exp_t        sb[$];
   int          hq[$];
   int          checks = 0, errors = 0;
   logic [16:0] m_alpha = 17'h08000, m_gamma = 17'h0E666;
   int          m_count = 0;
   logic [31:0] last_q = '0;
   logic [7:0]  last_tag = '0;
   logic        last_sat = 1'b0;
   int          last_cyc = 0, acc_cyc = 0;

   function automatic exp_t ref_model(input logic [31:0] q, mq, r, input logic [7:0] tag,
                                      input logic [16:0] a, g);
      exp_t   e;
      longint qs   = longint'($signed(q));
      longint ms   = longint'($signed(mq));
      longint rs   = longint'($signed(r));
      longint lim2 = longint'(1) <<< (W + 1);
      longint lim  = longint'(1) <<< (W - 1);
      longint td, u, s;
      e.sat = 1'b0;
      td = ((longint'(g) * ms) >>> F) + (rs - qs);
      u  = (longint'(a) * td) >>> F;
      if (u > lim2 - 1) begin u = lim2 - 1; e.sat = 1'b1; end
      else if (u < -lim2) begin u = -lim2; e.sat = 1'b1; end
      s = qs + u;
      if (s > lim - 1) begin s = lim - 1; e.sat = 1'b1; end
      else if (s < -lim) begin s = -lim; e.sat = 1'b1; end
      e.q   = s[31:0];
      e.tag = tag;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on every handoff, and checks held outputs while stalled.
   logic        prev_stall = 1'b0;
   logic [31:0] pq;
   logic [7:0]  ptag;
   logic        psat;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid", 64'(o_valid), 64'd1);
               chk("stall_q", 64'(o_q_new), 64'(pq));
               chk("stall_tag", 64'(o_tag), 64'(ptag));
               chk("stall_sat", 64'(o_sat), 64'(psat));
            end
            if (o_valid && i_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got q=%0h tag=%0h, required no output", o_q_new, o_tag);
               end else begin
                  e = sb.pop_front();
                  chk("q_new", 64'(o_q_new), 64'(e.q));
                  chk("tag", 64'(o_tag), 64'(e.tag));
                  chk("sat", 64'(o_sat), 64'(e.sat));
                  chk("sat_count", 64'(o_sat_count), 64'(m_count));
                  if (e.sat && m_count < 65535) m_count++;
               end
               last_q   = o_q_new;
               last_tag = o_tag;
               last_sat = o_sat;
               last_cyc = cyc;
               hq.push_back(cyc);
            end
            prev_stall = o_valid && !i_ready;
            pq   = o_q_new;
            ptag = o_tag;
            psat = o_sat;
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] q, mq, r, input logic [7:0] tag,
                        input logic rdy, output logic acc);
      @(negedge clk);
      i_valid = v; i_q = q; i_max_q = mq; i_rt = r; i_tag = tag;
      i_ready = rdy; cfg_we = 1'b0;
      #1;
      acc = v && o_ready;
      if (acc) begin
         sb.push_back(ref_model(q, mq, r, tag, m_alpha, m_gamma));
         acc_cyc = cyc;
      end
   endtask

   task automatic send(input logic [31:0] q, mq, r, input logic [7:0] tag, input bit rnd_rdy);
      logic acc = 1'b0;
      for (int k = 0; k < 200 && !acc; k++)
         drive(1'b1, q, mq, r, tag, rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int k = 0; k < n; k++) drive(1'b0, '0, '0, '0, '0, 1'b1, acc);
   endtask

   task automatic drain();
      logic acc;
      for (int k = 0; k < 200 && sb.size() > 0; k++) drive(1'b0, '0, '0, '0, '0, 1'b1, acc);
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic cfg(input logic [16:0] a, g);
      @(negedge clk);
      cfg_we = 1'b1; cfg_alpha = a; cfg_gamma = g; i_valid = 1'b0; i_ready = 1'b1;
      #1;
      m_alpha = a;
      m_gamma = g;
   endtask

   function automatic logic [31:0] rnd_data();
      if ($urandom_range(0, 3) == 0) return 32'($urandom);
      return 32'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      repeat (3) @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_q", 64'(o_q_new), 64'd0);
      chk("rst_tag", 64'(o_tag), 64'd0);
      chk("rst_sat", 64'(o_sat), 64'd0);
      chk("rst_count", 64'(o_sat_count), 64'd0);
      chk("rst_ready", 64'(o_ready), 64'd1);

      // Basic update and exact latency
      send(32'h0001_0000, 32'h0002_0000, 32'h0001_0000, 8'h5A, 1'b0);
      drain();
      chk("basic_q", 64'(last_q), 64'h1E666);
      chk("basic_tag", 64'(last_tag), 64'h5A);
      chk("basic_sat", 64'(last_sat), 64'd0);
      chk("basic_latency", 64'(last_cyc - acc_cyc), 64'd4);

      // Positive and negative saturation
      cfg(17'h10000, 17'h10000);
      send(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 8'h01, 1'b0);
      drain();
      chk("satp_q", 64'(last_q), 64'h7FFFFFFF);
      chk("satp_flag", 64'(last_sat), 64'd1);
      chk("satp_count", 64'(o_sat_count), 64'd1);
      send(32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 8'h02, 1'b0);
      drain();
      chk("satn_q", 64'(last_q), 64'h80000000);
      chk("satn_flag", 64'(last_sat), 64'd1);
      chk("satn_count", 64'(o_sat_count), 64'd2);

      // Back-to-back stream at full throughput
      cfg(17'h08000, 17'h0E666);
      idle(1);
      hq.delete();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, rnd_data(), rnd_data(), rnd_data(), 8'(i), 1'b1, acc);
         chk("stream_accept", 64'(acc), 64'd1);
         chk("stream_ready", 64'(o_ready), 64'd1);
      end
      drain();
      chk("stream_count", 64'(hq.size()), 64'd16);
      if (hq.size() == 16) chk("stream_span", 64'(hq[15] - hq[0]), 64'd15);

      // Random back-pressure with occasional coefficient changes
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 24) == 0)
            cfg(17'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 32'h1FFFF : 32'h10000)),
                17'($urandom_range(0, 32'h10000)));
         send(rnd_data(), rnd_data(), rnd_data(), 8'($urandom), 1'b1);
      end
      drain();

      // Coefficient change with beats still in flight
      cfg(17'h08000, 17'h0E666);
      for (int i = 0; i < 4; i++) send(rnd_data(), rnd_data(), rnd_data(), 8'(8'h40 + i), 1'b0);
      cfg(17'h10000, 17'h0E666);
      for (int i = 4; i < 8; i++) send(rnd_data(), rnd_data(), rnd_data(), 8'(8'h40 + i), 1'b0);
      drain();

      // Reset with three beats in flight; rst must win over cfg_we and i_valid
      for (int i = 0; i < 3; i++) send(rnd_data(), rnd_data(), rnd_data(), 8'(8'h80 + i), 1'b0);
      @(negedge clk);
      rst = 1'b1; cfg_we = 1'b1; cfg_alpha = 17'h01234; cfg_gamma = 17'h01234;
      i_valid = 1'b1; i_ready = 1'b1;
      sb.delete();
      m_alpha = 17'h08000; m_gamma = 17'h0E666; m_count = 0;
      @(negedge clk);
      rst = 1'b0; cfg_we = 1'b0; i_valid = 1'b0;
      #1;
      chk("midrst_valid", 64'(o_valid), 64'd0);
      chk("midrst_count", 64'(o_sat_count), 64'd0);
      idle(8);
      send(32'h0001_0000, 32'h0002_0000, 32'h0001_0000, 8'hC3, 1'b0);
      drain();
      chk("postrst_q", 64'(last_q), 64'h1E666);
      chk("postrst_tag", 64'(last_tag), 64'hC3);
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
